// File: rtl/mc_ctrl.sv
// Multicycle MIPS main control: Moore FSM stepping each instruction through
// fetch/decode/execute/memory/writeback and driving every datapath strobe.
module mc_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic [1:0] PCSource,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [3:0] state,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RCOMPL = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    state_t cur, nxt;

    always_comb begin
        nxt = S_FETCH;
        case (cur)
            S_FETCH:  nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: nxt = S_MEMADR;
                    OP_R:         nxt = S_EXEC;
                    OP_BEQ:       nxt = S_BRANCH;
                    OP_J:         nxt = S_JUMP;
                    OP_ADDI:      nxt = S_ADDIEX;
                    default:      nxt = S_FETCH;
                endcase
            end
            S_MEMADR: nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  nxt = S_MEMWB;
            S_EXEC:   nxt = S_RCOMPL;
            S_ADDIEX: nxt = S_ADDIWB;
            default:  nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cur <= S_FETCH;
        else     cur <= nxt;
    end

    assign state = cur;

    // Strobes are gated by rst so nothing fires while reset is held,
    // even though the state already sits in FETCH.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = 2'b00;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        illegal     = 1'b0;
        if (!rst) begin
            case (cur)
                S_FETCH: begin
                    MemRead = 1'b1;
                    IRWrite = 1'b1;
                    ALUSrcB = 2'b01;
                    PCWrite = 1'b1;
                end
                S_DECODE: begin
                    ALUSrcB = 2'b11;
                    illegal = !(opcode inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI});
                end
                S_MEMADR, S_ADDIEX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                S_RCOMPL: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                end
                S_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                end
                S_ADDIWB: RegWrite = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: stimulus queues the expected per-cycle output
// vector, a negedge monitor pops and compares; then a random invariant soak.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'b0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal;
    logic [1:0] PCSource, ALUSrcB, ALUOp;
    logic [3:0] state;

    typedef struct packed {
        logic [3:0] st;
        logic       ill;
        logic       PCWrite;
        logic       PCWriteCond;
        logic [1:0] PCSource;
        logic       IorD;
        logic       MemRead;
        logic       MemWrite;
        logic       IRWrite;
        logic       MemtoReg;
        logic       RegDst;
        logic       RegWrite;
        logic       ALUSrcA;
        logic [1:0] ALUSrcB;
        logic [1:0] ALUOp;
    } ov_t;

    ov_t act;
    ov_t exp_q[$];
    int  checks = 0;
    int  failures = 0;
    bit  soak = 1'b0;

    assign act = {state, illegal, PCWrite, PCWriteCond, PCSource, IorD, MemRead,
                  MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp};

    mc_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .state(state), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Hand-written per-state strobe table.
    function automatic ov_t exp_ov(input int s, input bit ill);
        ov_t o = '0;
        o.st  = s[3:0];
        o.ill = ill;
        case (s)
            0:  begin o.MemRead = 1; o.IRWrite = 1; o.ALUSrcB = 2'b01; o.PCWrite = 1; end
            1:  o.ALUSrcB = 2'b11;
            2:  begin o.ALUSrcA = 1; o.ALUSrcB = 2'b10; end
            3:  begin o.MemRead = 1; o.IorD = 1; end
            4:  begin o.RegWrite = 1; o.MemtoReg = 1; end
            5:  begin o.MemWrite = 1; o.IorD = 1; end
            6:  begin o.ALUSrcA = 1; o.ALUOp = 2'b10; end
            7:  begin o.RegWrite = 1; o.RegDst = 1; end
            8:  begin o.ALUSrcA = 1; o.ALUOp = 2'b01; o.PCWriteCond = 1; o.PCSource = 2'b01; end
            9:  begin o.PCWrite = 1; o.PCSource = 2'b10; end
            10: begin o.ALUSrcA = 1; o.ALUSrcB = 2'b10; end
            11: o.RegWrite = 1;
            default: ;
        endcase
        return o;
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            ov_t e;
            e = exp_q.pop_front();
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL vec[st=%0d] actual=%h required=%h", e.st, act, e);
            end
        end
        if (soak) begin
            checks++;
            if (PCWrite && PCSource[0]) begin
                failures++;
                $display("FAIL inv_pcsrc actual PCSource=%b with PCWrite=1 required 00/10", PCSource);
            end
            if (MemRead && MemWrite) begin
                failures++;
                $display("FAIL inv_mem actual MemRead=1 MemWrite=1 required not both");
            end
            if (PCWrite && PCWriteCond) begin
                failures++;
                $display("FAIL inv_pcw actual PCWrite=1 PCWriteCond=1 required not both");
            end
            if (rst && act !== '0) begin
                failures++;
                $display("FAIL rst_quiet actual=%h required=0", act);
            end
        end
    end

    task automatic step(input logic [5:0] op, input int s, input bit ill);
        @(posedge clk);
        #1;
        opcode = op;
        exp_q.push_back(exp_ov(s, ill));
    endtask

    // Runs the post-FETCH states of one instruction, optionally followed by
    // the next FETCH (with a junk opcode, which FETCH must ignore).
    task automatic instr(input logic [5:0] op, input int seq[4], input int n,
                         input bit ill, input bit fin);
        for (int i = 0; i < n; i++) step(op, seq[i], ill && seq[i] == 1);
        if (fin) step(6'b111111, 0, 1'b0);
    endtask

    task automatic direct_check(input string name, input ov_t e);
        checks++;
        if (act !== e) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, e);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual pending=%0d required 0", exp_q.size());
        end
    endtask

    initial begin
        #3;
        direct_check("reset_state", '0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        opcode = 6'b101010;
        exp_q.push_back(exp_ov(0, 1'b0));

        instr(6'b100011, '{1, 2, 3, 4}, 4, 1'b0, 1'b1);   // lw
        instr(6'b101011, '{1, 2, 5, 0}, 3, 1'b0, 1'b1);   // sw
        instr(6'b000000, '{1, 6, 7, 0}, 3, 1'b0, 1'b1);   // R-type
        instr(6'b000100, '{1, 8, 0, 0}, 2, 1'b0, 1'b1);   // beq
        instr(6'b000010, '{1, 9, 0, 0}, 2, 1'b0, 1'b1);   // j
        instr(6'b001000, '{1, 10, 11, 0}, 3, 1'b0, 1'b1); // addi
        instr(6'b111111, '{1, 0, 0, 0}, 1, 1'b1, 1'b1);   // illegal

        // lw aborted by reset while in MEMRD
        instr(6'b100011, '{1, 2, 3, 0}, 3, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        direct_check("reset_mid_memrd", '0);
        @(posedge clk);
        #1;
        direct_check("reset_held", '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.push_back(exp_ov(0, 1'b0));
        instr(6'b000010, '{1, 9, 0, 0}, 2, 1'b0, 1'b1);
        drain();

        soak = 1'b1;
        for (int c = 0; c < 12000; c++) begin
            @(posedge clk);
            #1;
            opcode = 6'($urandom);
            if (rst) rst = ($urandom_range(0, 1) == 0);
            else     rst = ($urandom_range(0, 149) == 0);
        end
        @(negedge clk);
        soak = 1'b0;
        rst = 1'b1;
        #1;
        direct_check("final_reset", '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multicycle main control unit for the MIPS datapath. A Moore state machine sequences each instruction through fetch, decode, execute, memory and writeback cycles and drives every datapath strobe, including the PC update controls `PCWrite`, `PCWriteCond` and `PCSource`. It sits beside the datapath and takes only the opcode field of the instruction register. The ALU `zero` flag goes straight to the PC block and is not routed here.

## Interface
- No parameters.
- `clk` input 1: system clock; all state changes on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `opcode` input 6: `IR[31:26]`; meaningful from the DECODE cycle onward.
- `PCWrite` output 1: unconditional PC load.
- `PCWriteCond` output 1: PC loads `ALUOut` when the PC block's `zero` is 1.
- `PCSource` output 2: 00 = ALU result (PC+4), 01 = branch (ALUOut), 10 = jump.
- `IorD` output 1: memory address select; 0 = PC, 1 = ALUOut.
- `MemRead` output 1: memory read strobe.
- `MemWrite` output 1: memory write strobe.
- `IRWrite` output 1: instruction register load.
- `MemtoReg` output 1: writeback data; 1 = MDR, 0 = ALUOut.
- `RegDst` output 1: destination register; 1 = rd, 0 = rt.
- `RegWrite` output 1: register file write.
- `ALUSrcA` output 1: 0 = PC, 1 = A.
- `ALUSrcB` output 2: 00 = B, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `ALUOp` output 2: 00 = add, 01 = subtract, 10 = use funct.
- `state` output 4: current state, for debug.
- `illegal` output 1: high during DECODE when the opcode is unsupported.

## Operation
- Supported opcodes:
  - R-type 000000
  - lw 100011
  - sw 101011
  - beq 000100
  - j 000010
  - addi 001000
- State encodings and their asserted outputs. Any output not listed is 0.
  - FETCH 0: MemRead, IRWrite, ALUSrcB=01, PCWrite, PCSource=00.
  - DECODE 1: ALUSrcB=11, ALUOp=00. The branch target is computed into ALUOut.
  - MEMADR 2: ALUSrcA, ALUSrcB=10.
  - MEMRD 3: MemRead, IorD.
  - MEMWB 4: RegWrite, MemtoReg, RegDst=0.
  - MEMWR 5: MemWrite, IorD.
  - EXEC 6: ALUSrcA, ALUSrcB=00, ALUOp=10.
  - RCOMPL 7: RegWrite, RegDst=1, MemtoReg=0.
  - BRANCH 8: ALUSrcA, ALUSrcB=00, ALUOp=01, PCWriteCond, PCSource=01.
  - JUMP 9: PCWrite, PCSource=10.
  - ADDIEX 10: ALUSrcA, ALUSrcB=10.
  - ADDIWB 11: RegWrite, RegDst=0, MemtoReg=0.
- Transitions:
  - FETCH → DECODE.
  - DECODE → by opcode:
    - lw or sw → MEMADR.
    - R-type → EXEC.
    - beq → BRANCH.
    - j → JUMP.
    - addi → ADDIEX.
    - any other opcode → FETCH, with `illegal`=1 for that cycle. The instruction is treated as a no-op; PC has already advanced by 4.
  - MEMADR → MEMRD for lw, MEMWR for sw.
  - MEMRD → MEMWB.
  - EXEC → RCOMPL.
  - ADDIEX → ADDIWB.
  - MEMWB, MEMWR, RCOMPL, BRANCH, JUMP and ADDIWB → FETCH.
  - Unused encodings 12–15 → FETCH, with all outputs 0 in that cycle.
- Outputs are a combinational function of `state` only, except `illegal`, which also depends on `opcode` in DECODE. Changing `opcode` outside DECODE and MEMADR has no effect.
- Invariant: `PCWrite`=1 only with `PCSource`=00 or 10. The PC block's next-PC mux is undefined for other codes when `PCWrite` is set.
- Invariant: `PCWrite` and `PCWriteCond` are never both 1.
- Invariant: `MemRead` and `MemWrite` are never both 1.

## Timing
- Reset:
  - `rst`=1 forces `state`=FETCH immediately, without waiting for a clock edge.
  - While `rst`=1, all control outputs and `illegal` are forced to 0.
  - The first FETCH strobes appear in the cycle after `rst` deasserts. The first fetch uses PC=0.
- Reset mid-instruction aborts the instruction. No further strobes are issued; in-flight register and memory writes do not occur after `rst` rises.
- Cycles per instruction, including FETCH:
  - lw 5.
  - sw, R-type and addi 4.
  - beq and j 3.
  - illegal 2.
- PC and IR load at the rising edge that ends FETCH.
- beq: the PC loads at the edge that ends BRANCH, and only if `zero`=1.
- j: the PC loads at the edge that ends JUMP.

## Test plan
- Reset: assert `rst` mid-MEMRD.
  - `state`=0 and all strobes 0 within the same cycle.
  - After release, FETCH strobes appear: MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=01.
- lw (opcode 100011): `state` sequence 0,1,2,3,4,0.
  - MemRead=1 with IorD=1 in state 3.
  - RegWrite=1 with MemtoReg=1 and RegDst=0 in state 4.
- sw (101011), then R-type (000000):
  - sw sequence 0,1,2,5,0, with MemWrite=1 only in state 5.
  - R-type sequence 0,1,6,7,0, with ALUOp=10 in state 6 and RegDst=1 in state 7.
- beq (000100), then j (000010):
  - BRANCH: PCWriteCond=1, PCWrite=0, ALUOp=01, PCSource=01.
  - JUMP: PCWrite=1, PCSource=10.
  - Each instruction completes in 3 cycles.
- addi (001000) and an illegal opcode (111111):
  - addi sequence 0,1,10,11,0.
  - Illegal opcode: sequence 0,1,0, with `illegal`=1 only in DECODE.
- Invariant check, with random opcodes and random mid-run resets over at least 10k cycles:
  - PCWrite never 1 with PCSource 01 or 11.
  - MemRead and MemWrite never 1 together.
  - PCWrite and PCWriteCond never 1 together.
